ber_stim_source: RTL and testbench

- Upstream stimulus stage for the BER measurement path. It drives the convolutional encoder and ber_tester with one frame, paced one symbol per strobe.
- Frame layout: a PRBS7 payload of total_bits bits, then TAIL_LEN zero bits to terminate the encoder, then FLUSH_LEN zero bits so the Viterbi traceback drains.
- It provides ref_valid, ref_bit, advance and the latched bit count that ber_tester consumes.

---
 rtl/ber_stim_source_pkg.sv | 27 ++
 rtl/prbs7_gen.sv | 30 +++
 rtl/ber_stim_source.sv | 160 ++++++++++++++++
 tb/tb_ber_stim_source.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ber_stim_source_pkg.sv
// Shared definitions for the BER stimulus source: FSM encoding and PRBS7 constants.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ber_stim_source_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_PAYLOAD = 3'd1;
    localparam state_t S_TAIL    = 3'd2;
    localparam state_t S_FLUSH   = 3'd3;
    localparam state_t S_FIN     = 3'd4;

    // x^7 + x^6 + 1: feedback taken from bits 6 and 5
    localparam logic [6:0] PRBS7_TAPS     = 7'h60;
    // An all-zero register would lock the generator, so it is replaced on load
    localparam logic [6:0] PRBS7_ZERO_SUB = 7'h7F;

    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], ^(s & PRBS7_TAPS)};
    endfunction

    function automatic logic [6:0] prbs7_seed_fix(input logic [6:0] s);
        return (s == 7'h00) ? PRBS7_ZERO_SUB : s;
    endfunction

endpackage

// File: rtl/prbs7_gen.sv
// PRBS7 generator with seed load and step enable; out_bit is the register MSB.
// Latency: out_bit reflects the state after the last load/step edge.
// Backpressure: none; advances only when step is high, load has priority.
module prbs7_gen
    import ber_stim_source_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [6:0] seed,
    input  logic       step,
    output logic       out_bit
);

    logic [6:0] lfsr_q;

    // Shift register: reload from seed (zero replaced) or step one position
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= PRBS7_ZERO_SUB;
        end else if (load) begin
            lfsr_q <= prbs7_seed_fix(seed);
        end else if (step) begin
            lfsr_q <= prbs7_next(lfsr_q);
        end
    end

    assign out_bit = lfsr_q[6];

endmodule

// File: rtl/ber_stim_source.sv
// Frame source for the BER path: PRBS7 payload, zero tail, zero flush, one symbol per strobe.
// Latency: first advance SYM_DIV cycles after the start edge; all outputs registered.
// Backpressure: none; the frame is paced purely by the internal symbol divider, abort cancels.
module ber_stim_source
    import ber_stim_source_pkg::*;
#(
    parameter int TAIL_LEN  = 6,
    parameter int FLUSH_LEN = 12,
    parameter int SYM_DIV   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] total_bits_in,
    input  logic [6:0]  seed,
    output logic        advance,
    output logic        ref_valid,
    output logic        ref_bit,
    output logic [15:0] total_bits,
    output logic        busy,
    output logic        done
);

    localparam int               DIV_W     = $clog2(SYM_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SYM_DIV - 1);
    localparam logic [15:0]      TAIL_LAST = 16'(TAIL_LEN - 1);
    localparam logic [15:0]      FLUSH_END = 16'(FLUSH_LEN);

    state_t           state_q, state_nxt;
    logic [DIV_W-1:0] div_q, div_nxt;
    logic [15:0]      cnt_q, cnt_nxt;
    logic [15:0]      total_bits_q, total_bits_nxt;

    logic prbs_load, prbs_step, prbs_bit;
    logic in_frame, strobe;
    logic adv_d, rv_d, rb_d, busy_d, done_d;

    assign in_frame = (state_q == S_PAYLOAD) || (state_q == S_TAIL) || (state_q == S_FLUSH);
    assign strobe   = in_frame && (div_q == DIV_LAST);

    prbs7_gen u_prbs (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (prbs_load),
        .seed    (seed),
        .step    (prbs_step),
        .out_bit (prbs_bit)
    );

    // State, divider, counter and latched length registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            div_q        <= '0;
            cnt_q        <= '0;
            total_bits_q <= '0;
        end else begin
            state_q      <= state_nxt;
            div_q        <= div_nxt;
            cnt_q        <= cnt_nxt;
            total_bits_q <= total_bits_nxt;
        end
    end

    // Next-state and datapath update; abort wins over every other event
    always_comb begin
        state_nxt      = state_q;
        div_nxt        = div_q;
        cnt_nxt        = cnt_q;
        total_bits_nxt = total_bits_q;
        prbs_load      = 1'b0;
        prbs_step      = 1'b0;
        if (abort) begin
            // counters and LFSR are left as-is; the next start reloads them
            state_nxt = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        total_bits_nxt = total_bits_in;
                        prbs_load      = 1'b1;
                        div_nxt        = '0;
                        cnt_nxt        = '0;
                        state_nxt      = (total_bits_in == 16'd0) ? S_TAIL : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    div_nxt = strobe ? '0 : div_q + DIV_W'(1);
                    if (strobe) begin
                        prbs_step = 1'b1;
                        // 17-bit compare so a length of 16'hFFFF ends before any wrap
                        if (({1'b0, cnt_q} + 17'd1) == {1'b0, total_bits_q}) begin
                            cnt_nxt   = '0;
                            state_nxt = S_TAIL;
                        end else begin
                            cnt_nxt = cnt_q + 16'd1;
                        end
                    end
                end
                S_TAIL: begin
                    div_nxt = strobe ? '0 : div_q + DIV_W'(1);
                    if (strobe) begin
                        if (cnt_q == TAIL_LAST) begin
                            cnt_nxt   = '0;
                            state_nxt = S_FLUSH;
                        end else begin
                            cnt_nxt = cnt_q + 16'd1;
                        end
                    end
                end
                S_FLUSH: begin
                    div_nxt = strobe ? '0 : div_q + DIV_W'(1);
                    // Leave one cycle after the last flush strobe so done lands a cycle
                    // after the final advance and busy drops together with done
                    if (cnt_q == FLUSH_END) begin
                        state_nxt = S_FIN;
                    end else if (strobe) begin
                        cnt_nxt = cnt_q + 16'd1;
                    end
                end
                S_FIN: begin
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    // Output decode ahead of the output registers; abort suppresses the strobe
    always_comb begin
        adv_d  = strobe && !abort;
        rv_d   = adv_d && (state_q == S_PAYLOAD);
        rb_d   = rv_d && prbs_bit;
        busy_d = (state_nxt == S_PAYLOAD) || (state_nxt == S_TAIL) || (state_nxt == S_FLUSH);
        done_d = (state_nxt == S_FIN);
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            advance   <= 1'b0;
            ref_valid <= 1'b0;
            ref_bit   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            advance   <= adv_d;
            ref_valid <= rv_d;
            ref_bit   <= rb_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign total_bits = total_bits_q;

endmodule

// File: tb/tb_ber_stim_source.sv
module tb_ber_stim_source;

    localparam int SD = 4;
    localparam int TL = 6;
    localparam int FL = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] total_bits_in;
    logic [6:0]  seed;
    logic        advance;
    logic        ref_valid;
    logic        ref_bit;
    logic [15:0] total_bits;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;

    logic model_bits [0:511];

    always #5 clk = ~clk;

    ber_stim_source #(
        .TAIL_LEN  (TL),
        .FLUSH_LEN (FL),
        .SYM_DIV   (SD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .total_bits_in (total_bits_in),
        .seed          (seed),
        .advance       (advance),
        .ref_valid     (ref_valid),
        .ref_bit       (ref_bit),
        .total_bits    (total_bits),
        .busy          (busy),
        .done          (done)
    );

    typedef struct {
        logic [15:0] tb;
        logic [6:0]  sd;
        int          restart_at;
        logic [15:0] restart_tb;
        int          exp_adv;
        int          exp_val;
        int          nbits;
        logic [63:0] exp_bits;
    } vec_t;

    vec_t vecs [0:5];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output bit sequence of x^7+x^6+1: first seven bits are the seed MSB-first,
    // thereafter o[n] = o[n-7] ^ o[n-6]
    function automatic void gen_model(input logic [6:0] sd, input int n);
        logic [6:0] s;
        s = (sd == 7'h00) ? 7'h7F : sd;
        for (int j = 0; j < 7; j++) model_bits[j] = s[6-j];
        for (int j = 7; j < n; j++) model_bits[j] = model_bits[j-7] ^ model_bits[j-6];
    endfunction

    // Starts a frame and checks every cycle against the frame timing model
    task automatic run_frame(input logic [15:0] tb, input logic [6:0] sd,
                             input int restart_at, input logic [15:0] restart_tb,
                             output int adv_cnt, output int val_cnt, output logic [63:0] seen);
        int n;
        int last;
        int k;
        int idx;
        logic e_adv, e_rv, e_rb, e_busy, e_done;
        n    = int'(tb) + TL + FL;
        last = n * SD;
        gen_model(sd, int'(tb));
        adv_cnt = 0;
        val_cnt = 0;
        seen    = '0;
        total_bits_in = tb;
        seed  = sd;
        start = 1'b1;
        tick();
        start = 1'b0;
        total_bits_in = 16'($urandom);
        seed = 7'($urandom);
        for (int i = 0; i <= last + 3; i++) begin
            k      = i / SD;
            idx    = (k > 0) ? k - 1 : 0;
            e_adv  = (i > 0) && (i % SD == 0) && (k <= n);
            e_rv   = e_adv && (k <= int'(tb));
            e_rb   = e_rv ? model_bits[idx] : 1'b0;
            e_busy = (i <= last);
            e_done = (i == last + 1);
            check($sformatf("frame_tb%0d_cyc%0d", tb, i),
                  {43'd0, total_bits, advance, ref_valid, ref_bit, busy, done},
                  {43'd0, tb, e_adv, e_rv, e_rb, e_busy, e_done});
            if (advance) adv_cnt++;
            if (ref_valid) begin
                val_cnt++;
                seen = {seen[62:0], ref_bit};
            end
            if (i == restart_at) begin
                start = 1'b1;
                total_bits_in = restart_tb;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic abort_case(input string nm, input logic [15:0] tb, input int at);
        int n_done;
        int n_adv;
        total_bits_in = tb;
        seed  = 7'h2B;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < at; i++) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check({nm, "_idle"}, {60'd0, busy, advance, ref_valid, done}, 64'd0);
        n_done = 0;
        n_adv  = 0;
        for (int i = 0; i < 120; i++) begin
            if (done) n_done++;
            if (advance) n_adv++;
            tick();
        end
        check({nm, "_no_done"}, 64'(n_done), 64'd0);
        check({nm, "_no_adv"}, 64'(n_adv), 64'd0);
    endtask

    initial begin
        int          adv_cnt;
        int          val_cnt;
        logic [63:0] seen;
        logic [15:0] rtb;
        logic [6:0]  rsd;

        //          tb     seed   restart  rtb  adv val nbits bits
        vecs[0] = '{16'd5,  7'h5A, -1,      16'd0, 23, 5,  0,  64'h0};
        vecs[1] = '{16'd14, 7'h00, -1,      16'd0, 32, 14, 14, 64'h3F81};
        vecs[2] = '{16'd0,  7'h11, -1,      16'd0, 18, 0,  0,  64'h0};
        vecs[3] = '{16'd10, 7'h33, 13,      16'd3, 28, 10, 0,  64'h0};
        vecs[4] = '{16'd1,  7'h40, -1,      16'd0, 19, 1,  1,  64'h1};
        vecs[5] = '{16'd2,  7'h19, 81,      16'd7, 20, 2,  0,  64'h0};

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        total_bits_in = 16'd0;
        seed = 7'd0;
        #12;
        check("reset_state", {43'd0, total_bits, advance, ref_valid, ref_bit, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_after_reset", {43'd0, total_bits, advance, ref_valid, ref_bit, busy, done}, 64'd0);

        // Table-driven frames
        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].tb, vecs[v].sd, vecs[v].restart_at, vecs[v].restart_tb,
                      adv_cnt, val_cnt, seen);
            check($sformatf("vec%0d_advances", v), 64'(adv_cnt), 64'(vecs[v].exp_adv));
            check($sformatf("vec%0d_valid", v), 64'(val_cnt), 64'(vecs[v].exp_val));
            if (vecs[v].nbits > 0)
                check($sformatf("vec%0d_bits", v), seen, vecs[v].exp_bits);
            tick();
        end

        // Randomized frames against the model
        for (int r = 0; r < 5; r++) begin
            rtb = 16'($urandom_range(0, 40));
            rsd = 7'($urandom);
            run_frame(rtb, rsd, -1, 16'd0, adv_cnt, val_cnt, seen);
            check($sformatf("rand%0d_advances", r), 64'(adv_cnt), 64'(int'(rtb) + TL + FL));
            check($sformatf("rand%0d_valid", r), 64'(val_cnt), 64'(rtb));
            tick();
        end

        // Abort in TAIL, then a full frame
        abort_case("abort_tail", 16'd3, 20);
        run_frame(16'd5, 7'h5A, -1, 16'd0, adv_cnt, val_cnt, seen);
        check("post_abort_tail_adv", 64'(adv_cnt), 64'd23);

        // Abort coincident with the final flush advance (frame of 21 symbols)
        abort_case("abort_final", 16'd3, (3 + TL + FL) * SD - 1);
        run_frame(16'd6, 7'h00, -1, 16'd0, adv_cnt, val_cnt, seen);
        check("post_abort_final_adv", 64'(adv_cnt), 64'd24);
        check("post_abort_final_bits", seen, 64'h3F);

        // Asynchronous reset mid-payload
        total_bits_in = 16'd8;
        seed  = 7'h05;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", {43'd0, total_bits, advance, ref_valid, ref_bit, busy, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        run_frame(16'd8, 7'h05, -1, 16'd0, adv_cnt, val_cnt, seen);
        check("post_reset_adv", 64'(adv_cnt), 64'd26);
        check("post_reset_valid", 64'(val_cnt), 64'd8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
